// File: rtl/spi_slave.sv
// ---------------------------------------------------------------------------
// spi_slave
//   SPI mode-0 target (CPOL=0, CPHA=0), MSB first. Acts as the responder for
//   the SD/SPI master in the autotest path and as an on-chip SD-card stand-in.
//   sclk, mosi and ss are oversampled in the clk domain through a
//   synchronizer chain followed by one edge-detect register.
//
// Ports
//   clk       in   1      system clock, sole clock of the block
//   rst_n     in   1      asynchronous, active-low reset
//   sclk      in   1      SPI clock from the master (asynchronous to clk)
//   mosi      in   1      SPI data from the master
//   ss        in   1      SPI select, active low
//   miso      out  1      SPI data to the master, 1 while deselected
//   tx_data   in   WIDTH  next byte to return to the master
//   tx_valid  in   1      tx_data valid
//   tx_ready  out  1      holding register empty (load on tx_valid&&tx_ready)
//   rx_data   out  WIDTH  last complete received byte
//   rx_valid  out  1      rx_data unread, held until rx_ack
//   rx_ack    in   1      consumer has taken rx_data
//   overrun   out  1      sticky: byte completed while rx_valid=1 and no ack
//   busy      out  1      synchronized select active (transfer in progress)
//   debug     out  32     {shift_out, shift_in, rx_data, 3'b0, state, bit_cnt}
// ---------------------------------------------------------------------------
module spi_slave #(
    parameter int               WIDTH       = 8,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] IDLE_BYTE   = 8'hFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sclk,
    input  logic             mosi,
    input  logic             ss,
    output logic             miso,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ack,
    output logic             overrun,
    output logic             busy,
    output logic [31:0]      debug
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Input synchronizers: stage 0 samples the pin, later stages are built
    // by the generate loop. ss resets to the deselected level.
    // -----------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_sync_reg;
    logic [SYNC_STAGES-1:0] mosi_sync_reg;
    logic [SYNC_STAGES-1:0] ss_sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_reg[0] <= 1'b0;
            mosi_sync_reg[0] <= 1'b0;
            ss_sync_reg[0]   <= 1'b1;
        end else begin
            sclk_sync_reg[0] <= sclk;
            mosi_sync_reg[0] <= mosi;
            ss_sync_reg[0]   <= ss;
        end
    end

    generate
        for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sclk_sync_reg[gi] <= 1'b0;
                    mosi_sync_reg[gi] <= 1'b0;
                    ss_sync_reg[gi]   <= 1'b1;
                end else begin
                    sclk_sync_reg[gi] <= sclk_sync_reg[gi-1];
                    mosi_sync_reg[gi] <= mosi_sync_reg[gi-1];
                    ss_sync_reg[gi]   <= ss_sync_reg[gi-1];
                end
            end
        end
    endgenerate

    logic sclk_s, mosi_s, ss_s;
    logic sclk_d_reg, ss_d_reg;
    logic sclk_rise, sclk_fall, ss_fall;

    assign sclk_s = sclk_sync_reg[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_reg[SYNC_STAGES-1];
    assign ss_s   = ss_sync_reg[SYNC_STAGES-1];

    // Edge register; mosi_s stays aligned with sclk_s because both chains
    // have the same depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_d_reg <= 1'b0;
            ss_d_reg   <= 1'b1;
        end else begin
            sclk_d_reg <= sclk_s;
            ss_d_reg   <= ss_s;
        end
    end

    assign sclk_rise = sclk_s & ~sclk_d_reg;
    assign sclk_fall = ~sclk_s & sclk_d_reg;
    assign ss_fall   = ~ss_s & ss_d_reg;

    // -----------------------------------------------------------------------
    // FSM: state register / next state / control strobes
    // -----------------------------------------------------------------------
    state_t state_reg, state_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (ss_fall) state_next = ST_LOAD;
            ST_LOAD:  state_next = ST_SHIFT;
            ST_SHIFT: state_next = ST_SHIFT;
            default:  state_next = ST_IDLE;
        endcase
        // Deselect wins from any state.
        if (ss_s) begin
            state_next = ST_IDLE;
        end
    end

    logic [CNT_W-1:0] bit_cnt_reg;
    logic idle_en, load_en, shift_en, sample_en;

    // A deselect seen during LOAD/SHIFT suppresses all datapath action, so a
    // queued tx byte is never consumed by a transfer that is being aborted.
    always_comb begin
        idle_en   = 1'b0;
        load_en   = 1'b0;
        shift_en  = 1'b0;
        sample_en = 1'b0;
        case (state_reg)
            ST_IDLE: idle_en = 1'b1;
            ST_LOAD: load_en = ~ss_s;
            ST_SHIFT: begin
                if (!ss_s) begin
                    if (sclk_rise) begin
                        sample_en = 1'b1;
                    end else if (sclk_fall) begin
                        // Byte boundary reloads instead of shifting, so
                        // consecutive bytes follow with no gap.
                        if (bit_cnt_reg == '0) begin
                            load_en = 1'b1;
                        end else begin
                            shift_en = 1'b1;
                        end
                    end
                end
            end
            default: idle_en = 1'b1;
        endcase
    end

    // -----------------------------------------------------------------------
    // tx holding register
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] hold_reg;
    logic             tx_full_reg;
    logic             tx_write;
    logic [WIDTH-1:0] load_byte;

    // Writes are only accepted while empty, so a write can never collide
    // with a consume of the same byte: a write in a load cycle lands in
    // hold for the following byte.
    assign tx_write  = tx_valid & ~tx_full_reg;
    assign tx_ready  = ~tx_full_reg;
    assign load_byte = tx_full_reg ? hold_reg : IDLE_BYTE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_reg    <= '0;
            tx_full_reg <= 1'b0;
        end else begin
            if (tx_write) begin
                hold_reg    <= tx_data;
                tx_full_reg <= 1'b1;
            end else if (load_en) begin
                tx_full_reg <= 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Shift datapath
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] shift_out_reg;
    logic [WIDTH-1:0] shift_in_reg;
    logic             miso_reg;
    logic             byte_done;

    assign byte_done = sample_en && (bit_cnt_reg == LAST_BIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_out_reg <= '0;
            shift_in_reg  <= '0;
            bit_cnt_reg   <= '0;
            miso_reg      <= 1'b1;
        end else begin
            if (idle_en) begin
                miso_reg     <= 1'b1;
                bit_cnt_reg  <= '0;
                shift_in_reg <= '0;
            end
            if (load_en) begin
                shift_out_reg <= load_byte;
                miso_reg      <= load_byte[WIDTH-1];
            end
            if (shift_en) begin
                shift_out_reg <= {shift_out_reg[WIDTH-2:0], 1'b0};
                miso_reg      <= shift_out_reg[WIDTH-2];
            end
            if (sample_en) begin
                shift_in_reg <= {shift_in_reg[WIDTH-2:0], mosi_s};
                bit_cnt_reg  <= (bit_cnt_reg == LAST_BIT) ? '0 : bit_cnt_reg + 1'b1;
            end
        end
    end

    assign miso = miso_reg;

    // -----------------------------------------------------------------------
    // rx port
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] rx_data_reg;
    logic             rx_valid_reg;
    logic             overrun_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data_reg  <= '0;
            rx_valid_reg <= 1'b0;
            overrun_reg  <= 1'b0;
        end else begin
            if (byte_done) begin
                // Newest byte always wins; an ack in the same cycle counts
                // as having read the previous one.
                rx_data_reg  <= {shift_in_reg[WIDTH-2:0], mosi_s};
                rx_valid_reg <= 1'b1;
                if (rx_valid_reg && !rx_ack) begin
                    overrun_reg <= 1'b1;
                end else if (rx_ack) begin
                    overrun_reg <= 1'b0;
                end
            end else if (rx_ack) begin
                rx_valid_reg <= 1'b0;
                overrun_reg  <= 1'b0;
            end
        end
    end

    assign rx_data  = rx_data_reg;
    assign rx_valid = rx_valid_reg;
    assign overrun  = overrun_reg;

    // -----------------------------------------------------------------------
    // busy / debug
    // -----------------------------------------------------------------------
    logic busy_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg <= 1'b0;
        end else begin
            busy_reg <= ~ss_s;
        end
    end

    assign busy  = busy_reg;
    assign debug = {8'(shift_out_reg), 8'(shift_in_reg), 8'(rx_data_reg),
                    3'b000, state_reg, 3'(bit_cnt_reg)};

endmodule

// File: tb/tb_spi_slave.sv
// ---------------------------------------------------------------------------
// tb_spi_slave
//   Bench for spi_slave: a mode-0 SPI master model driven from a vector
//   table plus hand-written sequences for overrun, abort, tx queueing during
//   a burst and mid-byte reset. Expected miso and rx bytes go through
//   scoreboard queues.
// ---------------------------------------------------------------------------
module tb_spi_slave;

    localparam int HALF = 8;   // sclk half-period in clk cycles
    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sclk, mosi, ss, miso;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_ack, overrun, busy;
    logic [31:0] debug;

    spi_slave #(.WIDTH(8), .SYNC_STAGES(SYNC), .IDLE_BYTE(8'hFF)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sclk     (sclk),
        .mosi     (mosi),
        .ss       (ss),
        .miso     (miso),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ack   (rx_ack),
        .overrun  (overrun),
        .busy     (busy),
        .debug    (debug)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    logic [7:0] sb_miso[$];
    logic [7:0] sb_rx[$];

    typedef struct {
        logic       queue_tx;
        logic [7:0] tx_b;
        logic [7:0] mosi_b;
        logic [7:0] exp_miso;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One transfer of nbits, MSB first. The master samples miso just before
    // raising sclk. With lat_chk, rx_valid is checked around the last rise.
    task automatic spi_xfer(input logic [7:0] out_b, input int nbits,
                            input bit lat_chk, output logic [7:0] in_b);
        in_b = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = out_b[7-i];
            wait_clk(HALF);
            in_b = {in_b[6:0], miso};
            sclk = 1'b1;
            if (lat_chk && i == 7) begin
                wait_clk(SYNC);
                check("rx_lat_early", 32'(rx_valid), 32'd0);
                wait_clk(2);
                check("rx_lat_due", 32'(rx_valid), 32'd1);
                wait_clk(HALF - SYNC - 2);
            end else begin
                wait_clk(HALF);
            end
            sclk = 1'b0;
        end
    endtask

    task automatic ss_low();
        ss = 1'b0;
    endtask

    task automatic ss_high();
        wait_clk(HALF);
        ss = 1'b1;
        wait_clk(HALF);
    endtask

    task automatic write_tx(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        wait_clk(1);
        tx_valid = 1'b0;
    endtask

    task automatic ack_rx();
        rx_ack = 1'b1;
        wait_clk(1);
        rx_ack = 1'b0;
    endtask

    task automatic wait_rx(input int bound);
        for (int k = 0; k < bound && !rx_valid; k++) wait_clk(1);
        check("rx_valid_seen", 32'(rx_valid), 32'd1);
    endtask

    task automatic pop_miso(input logic [7:0] got);
        logic [7:0] e;
        if (sb_miso.size() == 0) begin
            check("sb_miso_empty", 32'd1, 32'd0);
        end else begin
            e = sb_miso.pop_front();
            check("miso_byte", 32'(got), 32'(e));
        end
    endtask

    task automatic pop_rx();
        logic [7:0] e;
        if (sb_rx.size() == 0) begin
            check("sb_rx_empty", 32'd1, 32'd0);
        end else begin
            e = sb_rx.pop_front();
            check("rx_data", 32'(rx_data), 32'(e));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_miso"},     32'(miso),     32'd1);
        check({tag, "_tx_ready"}, 32'(tx_ready), 32'd1);
        check({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
        check({tag, "_rx_data"},  32'(rx_data),  32'd0);
        check({tag, "_overrun"},  32'(overrun),  32'd0);
        check({tag, "_busy"},     32'(busy),     32'd0);
    endtask

    initial begin
        logic [7:0] got, got1, got2;

        // queue_tx, tx_b, mosi_b, exp_miso, exp_rx
        vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
        vecs[1] = '{1'b0, 8'h00, 8'h00, 8'hFF, 8'h00};
        vecs[2] = '{1'b1, 8'h5A, 8'hFF, 8'h5A, 8'hFF};
        vecs[3] = '{1'b0, 8'h00, 8'h81, 8'hFF, 8'h81};

        rst_n = 1'b0; sclk = 1'b0; mosi = 1'b0; ss = 1'b1;
        tx_data = '0; tx_valid = 1'b0; rx_ack = 1'b0;
        wait_clk(3);
        check_reset_outputs("rst");
        check("rst_debug", debug, 32'd0);
        rst_n = 1'b1;
        wait_clk(4);

        // Single-byte transfers from the table
        for (int v = 0; v < 4; v++) begin
            if (vecs[v].queue_tx) begin
                write_tx(vecs[v].tx_b);
                check("tx_ready_after_write", 32'(tx_ready), 32'd0);
            end
            sb_miso.push_back(vecs[v].exp_miso);
            sb_rx.push_back(vecs[v].exp_rx);
            ss_low();
            spi_xfer(vecs[v].mosi_b, 8, 1'b1, got);
            check("busy_in_xfer", 32'(busy), 32'd1);
            ss_high();
            pop_miso(got);
            wait_rx(20);
            pop_rx();
            ack_rx();
            check("rx_valid_after_ack", 32'(rx_valid), 32'd0);
            check("busy_after_ss", 32'(busy), 32'd0);
            $display("vec %0d: mosi %02h miso %02h rx %02h", v, vecs[v].mosi_b, got, rx_data);
        end

        // Back-to-back bytes without ack -> overrun
        sb_miso.push_back(8'hFF);
        sb_miso.push_back(8'hFF);
        ss_low();
        spi_xfer(8'h11, 8, 1'b0, got1);
        spi_xfer(8'h22, 8, 1'b0, got2);
        ss_high();
        pop_miso(got1);
        pop_miso(got2);
        check("ovr_rx_data",  32'(rx_data),  32'h22);
        check("ovr_rx_valid", 32'(rx_valid), 32'd1);
        check("ovr_overrun",  32'(overrun),  32'd1);
        ack_rx();
        check("ovr_ack_valid",   32'(rx_valid), 32'd0);
        check("ovr_ack_overrun", 32'(overrun),  32'd0);
        $display("overrun seq: rx %02h", rx_data);

        // Abort after 5 bits, then a full byte re-aligns
        ss_low();
        spi_xfer(8'hF0, 5, 1'b0, got);
        ss_high();
        wait_clk(10);
        check("abort_no_rx_valid", 32'(rx_valid), 32'd0);
        sb_miso.push_back(8'hFF);
        sb_rx.push_back(8'h5A);
        ss_low();
        spi_xfer(8'h5A, 8, 1'b0, got);
        ss_high();
        pop_miso(got);
        wait_rx(20);
        pop_rx();
        ack_rx();
        $display("abort seq: rx %02h", rx_data);

        // Queue a tx byte during byte 1 of a 2-byte burst
        sb_miso.push_back(8'hFF);
        sb_miso.push_back(8'hC3);
        sb_rx.push_back(8'h34);
        ss_low();
        fork
            begin
                spi_xfer(8'h12, 8, 1'b0, got1);
                check("burst_tx_ready_b1_end", 32'(tx_ready), 32'd0);
                spi_xfer(8'h34, 8, 1'b0, got2);
                check("burst_tx_ready_b2", 32'(tx_ready), 32'd1);
            end
            begin
                wait_clk(40);
                check("burst_tx_ready_pre", 32'(tx_ready), 32'd1);
                write_tx(8'hC3);
                check("burst_tx_ready_drop", 32'(tx_ready), 32'd0);
            end
        join
        ss_high();
        pop_miso(got1);
        pop_miso(got2);
        pop_rx();
        ack_rx();
        check("burst_ack_overrun", 32'(overrun), 32'd0);
        $display("burst seq: miso %02h %02h", got1, got2);

        // Reset pulse at bit 4, then a clean transfer
        ss_low();
        spi_xfer(8'hAA, 4, 1'b0, got);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        wait_clk(2);
        ss = 1'b1;
        wait_clk(2);
        rst_n = 1'b1;
        wait_clk(4);
        sb_miso.push_back(8'hFF);
        sb_rx.push_back(8'h96);
        ss_low();
        spi_xfer(8'h96, 8, 1'b1, got);
        ss_high();
        pop_miso(got);
        wait_rx(20);
        pop_rx();
        ack_rx();
        $display("reset seq: rx %02h", rx_data);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
